// File: rtl/mem_initiator.sv
// Memory test initiator: writes a seeded incrementing pattern over an address
// range, reads it back through the single-port valid/ready interface, and
// reports mismatches and WAIT timeouts.
module mem_initiator #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = ADDR_WIDTH + 1,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [CNT_WIDTH-1:0]  count_i,
  input  logic [WIDTH-1:0]      seed_i,
  input  logic                  mode_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_WIDTH-1:0]  err_cnt_o,
  output logic [ADDR_WIDTH-1:0] first_err_addr_o,
  output logic                  timeout_o,
  output logic                  mem_valid_o,
  output logic                  mem_wr_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  input  logic                  mem_ready_i
);

  // The WAIT counter only has to reach TIMEOUT-1.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [TW-1:0]         WAIT_LIMIT = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0]         TW_ONE     = 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W    = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;
  localparam logic [WIDTH-1:0]      DATA_ONE   = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CNT_WIDTH-1:0]  n_q;
  logic [WIDTH-1:0]      seed_q;
  logic                  mode_q;
  logic [CNT_WIDTH-1:0]  k_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      data_q;
  logic                  wr_q;
  logic [TW-1:0]         wait_cnt_q;
  logic [CNT_WIDTH-1:0]  err_cnt_q;
  logic [ADDR_WIDTH-1:0] first_err_q;
  logic                  timeout_q;

  logic [ADDR_WIDTH-1:0] base_eff;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  last_k;
  logic                  last_op;
  logic                  wait_expired;
  logic                  rd_mismatch;

  // An out-of-range base address starts the run at word 0.
  assign base_eff     = ({1'b0, base_addr_i} >= DEPTH_W) ? '0 : base_addr_i;
  assign next_addr    = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_ONE;
  assign last_k       = (k_q == n_q - CNT_ONE);
  // Both orders finish on the read of the last word.
  assign last_op      = !wr_q && last_k;
  assign wait_expired = (state_q == WAIT) && !mem_ready_i && (wait_cnt_q == WAIT_LIMIT);
  assign rd_mismatch  = (state_q == WAIT) && mem_ready_i && !wr_q && (mem_rdata_i != data_q);

  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign timeout_o        = timeout_q;
  assign mem_wr_rd_o      = wr_q;
  assign mem_addr_o       = addr_q;
  assign mem_wdata_o      = wr_q ? data_q : '0;

  // State register; reset drops the request and status strobes at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode plus the state-derived strobes.
  always_comb begin
    state_d     = state_q;
    busy_o      = (state_q != IDLE);
    done_o      = (state_q == DONE);
    mem_valid_o = (state_q == ISSUE);
    case (state_q)
      IDLE:    if (start_i) state_d = (count_i == '0) ? DONE : ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT: begin
        if (mem_ready_i)       state_d = last_op ? DONE : ISSUE;
        else if (wait_expired) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Run parameters, current transaction, WAIT timer and result status.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q      <= '0;
      n_q         <= '0;
      seed_q      <= '0;
      mode_q      <= 1'b0;
      k_q         <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      wr_q        <= 1'b0;
      wait_cnt_q  <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            base_q      <= base_eff;
            n_q         <= count_i;
            seed_q      <= seed_i;
            mode_q      <= mode_i;
            k_q         <= '0;
            addr_q      <= base_eff;
            data_q      <= seed_i;
            wr_q        <= 1'b1;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            timeout_q   <= 1'b0;
          end
        end
        ISSUE: wait_cnt_q <= '0;
        WAIT: begin
          if (mem_ready_i) begin
            if (rd_mismatch) begin
              if (err_cnt_q == '0)     first_err_q <= addr_q;
              if (err_cnt_q != CNT_MAX) err_cnt_q  <= err_cnt_q + CNT_ONE;
            end
            if (!last_op) begin
              if (wr_q && !mode_q) begin
                wr_q <= 1'b0;
              end else if (wr_q && mode_q && last_k) begin
                k_q    <= '0;
                addr_q <= base_q;
                data_q <= seed_q;
                wr_q   <= 1'b0;
              end else begin
                k_q    <= k_q + CNT_ONE;
                addr_q <= next_addr;
                data_q <= data_q + DATA_ONE;
                if (!mode_q) wr_q <= 1'b1;
              end
            end
          end else if (wait_expired) begin
            timeout_q <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + TW_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_initiator.sv
// Self-checking bench for mem_initiator: a behavioural memory with optional
// response delay, read corruption and hang, checked against a pattern model.
module tb_mem_initiator;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 512;
  localparam int AW      = 9;
  localparam int CW      = 10;
  localparam int TIMEOUT = 15;
  localparam logic [WIDTH-1:0] CORRUPT_MASK = 16'h8001;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [WIDTH-1:0] wdata;
  } bus_t;

  logic             clk;
  logic             rst_ni;
  logic             start_i;
  logic [AW-1:0]    base_addr_i;
  logic [CW-1:0]    count_i;
  logic [WIDTH-1:0] seed_i;
  logic             mode_i;
  logic             busy_o;
  logic             done_o;
  logic [CW-1:0]    err_cnt_o;
  logic [AW-1:0]    first_err_addr_o;
  logic             timeout_o;
  logic             mem_valid_o;
  logic             mem_wr_rd_o;
  logic [AW-1:0]    mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic [WIDTH-1:0] mem_rdata_i;
  logic             mem_ready_i;

  mem_initiator #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .start_i(start_i),
    .base_addr_i(base_addr_i),
    .count_i(count_i),
    .seed_i(seed_i),
    .mode_i(mode_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_cnt_o(err_cnt_o),
    .first_err_addr_o(first_err_addr_o),
    .timeout_o(timeout_o),
    .mem_valid_o(mem_valid_o),
    .mem_wr_rd_o(mem_wr_rd_o),
    .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i)
  );

  logic [WIDTH-1:0] mem    [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];
  bit               corrupt[DEPTH];
  bus_t             log_q[$];
  bus_t             exp_q[$];
  int               delay_q[$];
  bus_t             mon_b;
  bit               hang;
  bit               pending;
  int               delay_left;
  logic [WIDTH-1:0] pend_data;

  int cyc;
  int n_checks;
  int n_fail;
  int exp_err;
  int exp_ferr;
  int exp_cycles;
  int done_rel;
  bit found;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time done_o relative to the accepted start.
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: takes a request seen in the ISSUE cycle, answers after 1+delay cycles.
  always @(negedge clk) begin
    if (!rst_ni) begin
      pending     = 1'b0;
      mem_ready_i = 1'b0;
    end else begin
      mem_ready_i = 1'b0;
      mem_rdata_i = WIDTH'($urandom);
      if (pending) begin
        if (delay_left == 0) begin
          mem_ready_i = 1'b1;
          mem_rdata_i = pend_data;
          pending     = 1'b0;
        end else begin
          delay_left--;
        end
      end
      if (mem_valid_o) begin
        mon_b = {mem_wr_rd_o, mem_addr_o, mem_wdata_o};
        log_q.push_back(mon_b);
        if (mem_wr_rd_o) begin
          mem[mem_addr_o] = mem_wdata_o;
          pend_data       = WIDTH'($urandom);
        end else begin
          pend_data = mem[mem_addr_o] ^ (corrupt[mem_addr_o] ? CORRUPT_MASK : '0);
        end
        if (!hang) begin
          pending    = 1'b1;
          delay_left = (delay_q.size() > 0) ? delay_q.pop_front() : 0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected bus sequence and read results, from the transaction rules alone.
  task automatic build_model(input int base, input int n, input int seed, input bit mode);
    int ks[$];
    bit ws[$];
    int errs;
    exp_q.delete();
    shadow   = mem;
    errs     = 0;
    exp_ferr = 0;
    for (int k = 0; k < n; k++) begin
      ws.push_back(1'b1); ks.push_back(k);
      if (!mode) begin ws.push_back(1'b0); ks.push_back(k); end
    end
    if (mode) for (int k = 0; k < n; k++) begin ws.push_back(1'b0); ks.push_back(k); end
    for (int j = 0; j < ws.size(); j++) begin
      int   a;
      int   d;
      bus_t b;
      logic [WIDTH-1:0] rd;
      a       = (base + ks[j]) % DEPTH;
      d       = (seed + ks[j]) % 65536;
      b.wr    = ws[j];
      b.addr  = a[AW-1:0];
      b.wdata = ws[j] ? d[WIDTH-1:0] : '0;
      exp_q.push_back(b);
      if (ws[j]) begin
        shadow[a] = d[WIDTH-1:0];
      end else begin
        rd = shadow[a] ^ (corrupt[a] ? CORRUPT_MASK : '0);
        if (rd != d[WIDTH-1:0]) begin
          if (errs == 0) exp_ferr = a;
          errs++;
        end
      end
    end
    exp_err = (errs > 1023) ? 1023 : errs;
  endtask

  task automatic apply_stimulus(input int base, input int n, input int seed, input bit mode,
                                input int max_delay, input bit poke);
    int start_edge;
    log_q.delete();
    delay_q.delete();
    exp_cycles = 0;
    for (int j = 0; j < 2 * n; j++) begin
      int d;
      d = (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
      delay_q.push_back(d);
      exp_cycles += 2 + d;
    end
    build_model(base, n, seed, mode);
    @(negedge clk);
    base_addr_i = base[AW-1:0];
    count_i     = n[CW-1:0];
    seed_i      = seed[WIDTH-1:0];
    mode_i      = mode;
    start_i     = 1'b1;
    @(negedge clk);
    start_i    = 1'b0;
    start_edge = cyc;
    found      = 1'b0;
    done_rel   = -1;
    for (int i = 0; i < exp_cycles + 40 && !found; i++) begin
      if (done_o === 1'b1) begin
        found    = 1'b1;
        done_rel = cyc - start_edge;
      end else begin
        if (poke && i == 2) begin
          start_i     = 1'b1;
          count_i     = ~count_i;
          base_addr_i = base_addr_i + 9'd5;
          mode_i      = ~mode_i;
          seed_i      = ~seed_i;
        end
        if (poke && i == 3) start_i = 1'b0;
        @(negedge clk);
      end
    end
    start_i = 1'b0;
  endtask

  task automatic check_output(input string tag);
    check({tag, ".done_seen"}, 32'(found), 1);
    check({tag, ".done_edge"}, done_rel, exp_cycles);
    check({tag, ".err_cnt"}, 32'(err_cnt_o), exp_err);
    check({tag, ".first_err"}, 32'(first_err_addr_o), exp_ferr);
    check({tag, ".timeout"}, 32'(timeout_o), 0);
    check({tag, ".num_req"}, log_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size(); j++)
      check($sformatf("%s.req%0d", tag, j), (j < log_q.size()) ? 32'(log_q[j]) : 32'hFFFF_FFFF,
            32'(exp_q[j]));
    @(negedge clk);
    check({tag, ".done_pulse"}, 32'(done_o), 0);
    check({tag, ".busy_end"}, 32'(busy_o), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    bit seen;
    rst_ni      = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    count_i     = '0;
    seed_i      = '0;
    mode_i      = 1'b0;
    mem_rdata_i = '0;
    mem_ready_i = 1'b0;
    hang        = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = WIDTH'($urandom);
      corrupt[i] = 1'b0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy_o), 0);
    check("rst.done", 32'(done_o), 0);
    check("rst.err_cnt", 32'(err_cnt_o), 0);
    check("rst.first_err", 32'(first_err_addr_o), 0);
    check("rst.timeout", 32'(timeout_o), 0);
    check("rst.valid", 32'(mem_valid_o), 0);
    check("rst.wr_rd", 32'(mem_wr_rd_o), 0);
    check("rst.addr", 32'(mem_addr_o), 0);
    check("rst.wdata", 32'(mem_wdata_o), 0);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);

    // Interleaved, 4 words from address 0
    $display("[TB] interleaved N=4");
    apply_stimulus(0, 4, 16'h1000, 1'b0, 0, 1'b0);
    check("ilv.w1_data", (log_q.size() > 2) ? 32'(log_q[2].wdata) : 32'hFFFF_FFFF, 32'h1001);
    check("ilv.r0_is_read", (log_q.size() > 1) ? 32'(log_q[1].wr) : 32'hFFFF_FFFF, 0);
    check_output("ilv");

    // Block mode wrapping the top of memory and the data seed
    $display("[TB] block wrap N=4");
    apply_stimulus(510, 4, 16'hFFFE, 1'b1, 0, 1'b0);
    check("wrap.w2_addr", (log_q.size() > 2) ? 32'(log_q[2].addr) : 32'hFFFF_FFFF, 0);
    check("wrap.w2_data", (log_q.size() > 2) ? 32'(log_q[2].wdata) : 32'hFFFF_FFFF, 0);
    check_output("wrap");

    // Corrupted read-back at addresses 2, then 2 and 3
    $display("[TB] corrupted reads");
    corrupt[2] = 1'b1;
    apply_stimulus(0, 4, int'($urandom), 1'b1, 0, 1'b0);
    check("cor1.err_exp", 32'(err_cnt_o), 1);
    check("cor1.first_exp", 32'(first_err_addr_o), 2);
    check_output("cor1");
    corrupt[3] = 1'b1;
    apply_stimulus(0, 4, int'($urandom), 1'b1, 0, 1'b0);
    check("cor2.err_exp", 32'(err_cnt_o), 2);
    check("cor2.first_exp", 32'(first_err_addr_o), 2);
    check_output("cor2");
    repeat (5) @(negedge clk);
    check("cor2.err_hold", 32'(err_cnt_o), 2);
    check("cor2.first_hold", 32'(first_err_addr_o), 2);
    corrupt[2] = 1'b0;
    corrupt[3] = 1'b0;

    // Memory never answers
    $display("[TB] timeout");
    hang = 1'b1;
    log_q.delete();
    delay_q.delete();
    @(negedge clk);
    base_addr_i = 9'd7;
    count_i     = 10'd3;
    seed_i      = 16'h0055;
    mode_i      = 1'b0;
    start_i     = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
    base     = cyc;
    found    = 1'b0;
    done_rel = -1;
    for (int i = 0; i < 60 && !found; i++) begin
      if (done_o === 1'b1) begin
        found    = 1'b1;
        done_rel = cyc - base;
      end else begin
        @(negedge clk);
      end
    end
    check("to.done_seen", 32'(found), 1);
    check("to.done_edge", done_rel, TIMEOUT + 1);
    check("to.timeout", 32'(timeout_o), 1);
    check("to.num_req", log_q.size(), 1);
    repeat (10) @(negedge clk);
    check("to.num_req_after", log_q.size(), 1);
    check("to.busy_end", 32'(busy_o), 0);
    check("to.timeout_hold", 32'(timeout_o), 1);
    hang = 1'b0;

    // Zero-length run, then a start pulse while busy
    $display("[TB] N=0 and start while busy");
    apply_stimulus(5, 0, 16'h2222, 1'b0, 0, 1'b0);
    check_output("zero");
    apply_stimulus(20, 5, 16'hABCD, 1'b0, 0, 1'b1);
    check_output("poke");

    // Reset during WAIT of a 4-word run
    $display("[TB] reset mid-run");
    @(negedge clk);
    base_addr_i = 9'd100;
    count_i     = 10'd4;
    seed_i      = 16'h1234;
    mode_i      = 1'b0;
    start_i     = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("mid.pre_addr", 32'(mem_addr_o), 100);
    check("mid.pre_busy", 32'(busy_o), 1);
    rst_ni = 1'b0;
    #1;
    check("mid.busy", 32'(busy_o), 0);
    check("mid.done", 32'(done_o), 0);
    check("mid.valid", 32'(mem_valid_o), 0);
    check("mid.wr_rd", 32'(mem_wr_rd_o), 0);
    check("mid.addr", 32'(mem_addr_o), 0);
    check("mid.wdata", 32'(mem_wdata_o), 0);
    check("mid.err_cnt", 32'(err_cnt_o), 0);
    check("mid.first_err", 32'(first_err_addr_o), 0);
    check("mid.timeout", 32'(timeout_o), 0);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done_o !== 1'b0) seen = 1'b1;
    end
    rst_ni = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done_o !== 1'b0) seen = 1'b1;
    end
    check("mid.no_done", 32'(seen), 0);
    apply_stimulus(100, 4, 16'h1234, 1'b0, 0, 1'b0);
    check_output("post_rst");

    // Random runs with response delays and scattered corruption
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < DEPTH; i++) corrupt[i] = 1'b0;
      base = int'($urandom_range(DEPTH - 1, 0));
      n    = int'($urandom_range(40, 1));
      corrupt[(base + int'($urandom_range(n - 1, 0))) % DEPTH] = 1'b1;
      corrupt[(base + int'($urandom_range(n - 1, 0))) % DEPTH] = 1'b1;
      $display("[TB] random run %0d base=%0d n=%0d", r, base, n);
      apply_stimulus(base, n, int'($urandom), bit'($urandom_range(1, 0)), 3, 1'b0);
      check_output($sformatf("rand%0d", r));
    end
    for (int i = 0; i < DEPTH; i++) corrupt[i] = 1'b0;

    // Block run longer than the memory: earlier writes get overwritten
    $display("[TB] block overlap N=1023");
    apply_stimulus(int'($urandom_range(DEPTH - 1, 0)), 1023, int'($urandom), 1'b1, 0, 1'b0);
    check("overlap.err_exp", 32'(err_cnt_o), 511);
    check_output("overlap");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
